// File: rtl/gpio_input_conditioner_if.sv
// Register-side bundle of the GPIO input conditioner.
// Per-pin controls flow in from the register block.
// The debounced level, event pulses and interrupt status flow back out.
interface gpio_input_conditioner_if #(
  parameter int NPINS      = 4,
  parameter int DEBOUNCE_W = 8
);
  logic [NPINS-1:0]      en;
  logic [DEBOUNCE_W-1:0] debounce_cycles;
  logic [NPINS-1:0]      irq_rise_en;
  logic [NPINS-1:0]      irq_fall_en;
  logic [NPINS-1:0]      irq_clear;
  logic [NPINS-1:0]      value;
  logic [NPINS-1:0]      rise_pulse;
  logic [NPINS-1:0]      fall_pulse;
  logic [NPINS-1:0]      irq_pending;
  logic                  irq;

  // Register block / interrupt controller side
  modport master (
    output en, debounce_cycles, irq_rise_en, irq_fall_en, irq_clear,
    input  value, rise_pulse, fall_pulse, irq_pending, irq
  );

  // Conditioner side
  modport slave (
    input  en, debounce_cycles, irq_rise_en, irq_fall_en, irq_clear,
    output value, rise_pulse, fall_pulse, irq_pending, irq
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner.
// Each pin is conditioned independently: the asynchronous pad value is
// synchronised into the clock domain and then debounced.
// Outputs are a stable level, one-cycle rise/fall pulses and a sticky,
// maskable interrupt.
// SYNC_STAGES must lie in 2..4.
module gpio_input_conditioner #(
  parameter int NPINS       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NPINS-1:0]       pad_i,
  output logic [NPINS-1:0]       ie,
  gpio_input_conditioner_if.slave regs
);

  logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
  logic [NPINS-1:0]                  s;
  logic [NPINS-1:0][DEBOUNCE_W-1:0]  cnt;
  logic [NPINS-1:0][DEBOUNCE_W-1:0]  cnt_nxt;
  logic [NPINS-1:0]                  value_q;
  logic [NPINS-1:0]                  value_nxt;
  logic [NPINS-1:0]                  rise_q;
  logic [NPINS-1:0]                  fall_q;
  logic [NPINS-1:0]                  pending_q;
  logic [NPINS-1:0]                  pending_set;

  assign s = sync_q[SYNC_STAGES-1];

  // Pad input enable is the per-pin enable delayed by one register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ie <= '0;
    end else begin
      ie <= regs.en;
    end
  end

  // Synchroniser chain: runs regardless of enable so a pin is settled when re-enabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Debounce decision per pin: disable, agree, commit, or keep counting (saturating)
  always_comb begin
    cnt_nxt   = cnt;
    value_nxt = value_q;
    for (int k = 0; k < NPINS; k++) begin
      if (!regs.en[k]) begin
        cnt_nxt[k] = '0;
      end else if (s[k] == value_q[k]) begin
        cnt_nxt[k] = '0;
      end else if (cnt[k] >= regs.debounce_cycles) begin
        value_nxt[k] = s[k];
        cnt_nxt[k]   = '0;
      end else if (cnt[k] != {DEBOUNCE_W{1'b1}}) begin
        cnt_nxt[k] = cnt[k] + DEBOUNCE_W'(1);
      end
    end
  end

  // Debounce state and the edge pulses, which align with the first cycle of a new level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      value_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cnt     <= cnt_nxt;
      value_q <= value_nxt;
      rise_q  <= value_nxt & ~value_q;
      fall_q  <= ~value_nxt & value_q;
    end
  end

  assign pending_set = (rise_q & regs.irq_rise_en) | (fall_q & regs.irq_fall_en);

  // Sticky interrupt status: write-1-to-clear, a coincident new event wins over the clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_set | (pending_q & ~regs.irq_clear);
    end
  end

  assign regs.value       = value_q;
  assign regs.rise_pulse  = rise_q;
  assign regs.fall_pulse  = fall_q;
  assign regs.irq_pending = pending_q;
  assign regs.irq         = |pending_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed testbench for gpio_input_conditioner.
// Expected results are queued when stimulus is applied and compared when the DUT output is due.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gpio_input_conditioner;
  localparam int NPINS       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE_W  = 8;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NPINS-1:0] pad_i;
  logic [NPINS-1:0] ie;
  exp_t             sb[$];
  int               compared   = 0;
  int               mismatched = 0;

  gpio_input_conditioner_if #(.NPINS(NPINS), .DEBOUNCE_W(DEBOUNCE_W)) regs ();

  gpio_input_conditioner #(
    .NPINS(NPINS), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pad_i(pad_i), .ie(ie), .regs(regs)
  );

  always #5 clock = ~clock;

  // Overall time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic exp_push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic obs_check(input logic [31:0] obs);
    exp_t item;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed 0x%0h expected none pending", obs);
      return;
    end
    item = sb.pop_front();
    assert (obs === item.exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", item.tag, obs, item.exp);
    end
  endtask

  initial begin
    reset_n                = 1'b0;
    pad_i                  = 4'b0101;
    regs.en                = '0;
    regs.debounce_cycles   = 8'd3;
    regs.irq_rise_en       = '0;
    regs.irq_fall_en       = '0;
    regs.irq_clear         = '0;
    step(2);

    // Reset state
    exp_push("reset_value", 0);    obs_check(32'(regs.value));
    exp_push("reset_ie", 0);       obs_check(32'(ie));
    exp_push("reset_pulses", 0);   obs_check(32'({regs.rise_pulse, regs.fall_pulse}));
    exp_push("reset_irq", 0);      obs_check(32'({regs.irq_pending, regs.irq}));

    // Release reset with the pad already at 0101; s appears after 2 edges, commit 3+1 later
    reset_n = 1'b1;
    regs.en = 4'hF;
    exp_push("ie_latency", 4'hF);
    step(1); obs_check(32'(ie));
    exp_push("pre_commit_value", 0);
    step(4); obs_check(32'(regs.value));
    exp_push("commit_value", 4'b0101);
    exp_push("commit_rise", 4'b0101);
    step(1); obs_check(32'(regs.value)); obs_check(32'(regs.rise_pulse));
    exp_push("rise_one_cycle", 0);
    step(1); obs_check(32'(regs.rise_pulse));

    // Settle pin0 at 0 with threshold 5: commit 2+5+1 = 8 edges after the pad edge
    regs.debounce_cycles = 8'd5;
    pad_i = 4'b0100;
    exp_push("fall_wait_value", 4'b0101);
    step(7); obs_check(32'(regs.value));
    exp_push("fall_value", 4'b0100);
    exp_push("fall_pulse0", 4'b0001);
    step(1); obs_check(32'(regs.value)); obs_check(32'(regs.fall_pulse));

    // Four-cycle glitch on pin0 is rejected
    pad_i = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) pad_i = 4'b0100;
      exp_push("glitch_value", 4'b0100);
      exp_push("glitch_pulses", 0);
      step(1);
      obs_check(32'(regs.value));
      obs_check(32'({regs.rise_pulse, regs.fall_pulse}));
    end

    // Held high: commits exactly 8 edges after the pad edge
    pad_i = 4'b0101;
    exp_push("hold_wait_value", 4'b0100);
    step(7); obs_check(32'(regs.value));
    exp_push("hold_value", 4'b0101);
    exp_push("hold_rise0", 4'b0001);
    step(1); obs_check(32'(regs.value)); obs_check(32'(regs.rise_pulse));
    step(2);

    // Interrupts on pin1: rise enabled, fall disabled; threshold 1 gives 4-edge latency
    regs.debounce_cycles = 8'd1;
    regs.irq_rise_en     = 4'b0010;
    regs.irq_fall_en     = 4'b0000;
    pad_i = 4'b0111;
    exp_push("irq_not_yet", 0);
    exp_push("rise1_pulse", 4'b0010);
    step(4); obs_check(32'(regs.irq_pending)); obs_check(32'(regs.rise_pulse));
    exp_push("rise1_pending", 5'b00101);
    step(1); obs_check(32'({regs.irq_pending, regs.irq}));
    regs.irq_clear = 4'b0010;
    exp_push("lone_clear1", 0);
    step(1); obs_check(32'({regs.irq_pending, regs.irq}));
    regs.irq_clear = '0;
    pad_i = 4'b0101;
    exp_push("fall1_pulse", 4'b0010);
    step(4); obs_check(32'(regs.fall_pulse));
    exp_push("fall1_no_irq", 0);
    step(1); obs_check(32'({regs.irq_pending, regs.irq}));
    pad_i = 4'b0111;
    step(4);
    regs.irq_clear = 4'b0010;
    exp_push("set_beats_clear", 5'b00101);
    step(1); obs_check(32'({regs.irq_pending, regs.irq}));
    regs.irq_clear   = '0;
    regs.irq_rise_en = '0;
    exp_push("en_change_keeps", 5'b00101);
    step(1); obs_check(32'({regs.irq_pending, regs.irq}));
    regs.irq_clear = 4'b0010;
    step(1);
    regs.irq_clear = '0;
    exp_push("lone_clear2", 0);
    obs_check(32'({regs.irq_pending, regs.irq}));

    // Threshold 0: value follows the pad SYNC_STAGES+1 edges later, counter stays 0
    regs.debounce_cycles = 8'd0;
    pad_i = 4'b1111;
    exp_push("dc0_cnt_a", 0);
    step(1); obs_check(32'(dut.cnt[3]));
    exp_push("dc0_cnt_b", 0);
    exp_push("dc0_value_wait", 4'b0111);
    step(1); obs_check(32'(dut.cnt[3])); obs_check(32'(regs.value));
    exp_push("dc0_cnt_c", 0);
    exp_push("dc0_value", 4'b1111);
    exp_push("dc0_rise3", 4'b1000);
    step(1);
    obs_check(32'(dut.cnt[3])); obs_check(32'(regs.value)); obs_check(32'(regs.rise_pulse));
    pad_i = 4'b0111;
    exp_push("dc0_fall_value", 4'b0111);
    exp_push("dc0_fall3", 4'b1000);
    step(3); obs_check(32'(regs.value)); obs_check(32'(regs.fall_pulse));

    // Threshold 6, pin2 falls; disable mid-count at cnt=2
    regs.debounce_cycles = 8'd6;
    pad_i = 4'b0011;
    exp_push("mid_cnt2", 2);
    step(4); obs_check(32'(dut.cnt[2]));
    regs.en = 4'b1011;
    exp_push("disabled_cnt2", 0);
    step(1); obs_check(32'(dut.cnt[2]));
    exp_push("disabled_value", 4'b0111);
    exp_push("disabled_pulses", 0);
    step(8); obs_check(32'(regs.value)); obs_check(32'({regs.rise_pulse, regs.fall_pulse}));

    // Asynchronous reset between edges clears outputs immediately
    #2 reset_n = 1'b0;
    #1;
    exp_push("async_value", 0);
    exp_push("async_ie", 0);
    exp_push("async_irq", 0);
    obs_check(32'(regs.value)); obs_check(32'(ie)); obs_check(32'({regs.irq_pending, regs.irq}));
    step(1);
    reset_n = 1'b1;
    regs.en = 4'hF;
    for (int i = 0; i < 8; i++) begin
      exp_push("post_reset_value", 0);
      exp_push("post_reset_pulses", 0);
      step(1);
      obs_check(32'(regs.value));
      obs_check(32'({regs.rise_pulse, regs.fall_pulse}));
    end
    exp_push("post_reset_commit", 4'b0011);
    exp_push("post_reset_rise", 4'b0011);
    step(1); obs_check(32'(regs.value)); obs_check(32'(regs.rise_pulse));
    step(2);

    // Lowering the threshold below the running count commits on the next edge
    regs.debounce_cycles = 8'd10;
    pad_i = 4'b1011;
    exp_push("lower_cnt3", 4);
    exp_push("lower_wait_value", 4'b0011);
    step(6); obs_check(32'(dut.cnt[3])); obs_check(32'(regs.value));
    regs.debounce_cycles = 8'd2;
    exp_push("lower_value", 4'b1011);
    exp_push("lower_rise3", 4'b1000);
    step(1); obs_check(32'(regs.value)); obs_check(32'(regs.rise_pulse));

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
